// File: rtl/cc_collision_handler_if.sv
// rtl/cc_collision_handler_if.sv - comparator/handler bus: lose flag, row data, tick/restart in; row, lives, controls out.
// Score_OutBus exists only when CC_COLLISION_HANDLER_SCORE_EN is defined.
interface cc_collision_handler_if #(
  parameter int DATAWIDTH  = 8,
  parameter int LIVESWIDTH = 2,
  parameter int SCOREWIDTH = 8
);
  logic                  PlayerLose_InLow;
  logic [DATAWIDTH-1:0]  RowData_InBus;
  logic                  Tick_InHigh;
  logic                  Restart_InHigh;
  logic [DATAWIDTH-1:0]  RowData_OutBus;
  logic [LIVESWIDTH-1:0] Lives_OutBus;
  logic                  Freeze_OutHigh;
  logic                  Respawn_OutHigh;
  logic                  GameOver_OutHigh;
`ifdef CC_COLLISION_HANDLER_SCORE_EN
  logic [SCOREWIDTH-1:0] Score_OutBus;
`endif

  modport master (
    output PlayerLose_InLow, RowData_InBus, Tick_InHigh, Restart_InHigh,
    input  RowData_OutBus, Lives_OutBus, Freeze_OutHigh, Respawn_OutHigh, GameOver_OutHigh
`ifdef CC_COLLISION_HANDLER_SCORE_EN
    , input Score_OutBus
`endif
  );

  modport slave (
    input  PlayerLose_InLow, RowData_InBus, Tick_InHigh, Restart_InHigh,
    output RowData_OutBus, Lives_OutBus, Freeze_OutHigh, Respawn_OutHigh, GameOver_OutHigh
`ifdef CC_COLLISION_HANDLER_SCORE_EN
    , output Score_OutBus
`endif
  );
endinterface

// File: rtl/cc_collision_handler.sv
// rtl/cc_collision_handler.sv - lives/game-over FSM with blinking hit row, respawn pulse and freeze control.
// Optional score counter enabled by CC_COLLISION_HANDLER_SCORE_EN.
module cc_collision_handler #(
  parameter int DATAWIDTH   = 8,
  parameter int LIVES_INIT  = 3,
  parameter int LIVESWIDTH  = 2,
  parameter int BLINK_TICKS = 6,
  parameter int BLINKWIDTH  = 3,
  parameter int SCOREWIDTH  = 8
) (
  input logic                    CC_COLLISION_HANDLER_CLOCK_50,
  input logic                    CC_COLLISION_HANDLER_RESET_InLow,
  cc_collision_handler_if.slave  bus
);
  typedef enum logic [1:0] {
    S_PLAY     = 2'd0,
    S_HIT      = 2'd1,
    S_RESPAWN  = 2'd2,
    S_GAMEOVER = 2'd3
  } state_t;

  localparam logic [LIVESWIDTH-1:0] LIVES_RST  = LIVESWIDTH'(LIVES_INIT);
  localparam logic [BLINKWIDTH-1:0] BLINK_LAST = BLINKWIDTH'(BLINK_TICKS - 1);

  state_t                r_state,   w_state_nxt;
  logic [DATAWIDTH-1:0]  r_row,     w_row_nxt;
  logic [DATAWIDTH-1:0]  r_held,    w_held_nxt;
  logic [LIVESWIDTH-1:0] r_lives,   w_lives_nxt;
  logic [BLINKWIDTH-1:0] r_blink,   w_blink_nxt;
  logic                  r_freeze,  w_freeze_nxt;
  logic                  r_respawn, w_respawn_nxt;
  logic                  r_gameover, w_gameover_nxt;
`ifdef CC_COLLISION_HANDLER_SCORE_EN
  logic [SCOREWIDTH-1:0] r_score,   w_score_nxt;
`endif

  always_ff @(posedge CC_COLLISION_HANDLER_CLOCK_50 or negedge CC_COLLISION_HANDLER_RESET_InLow) begin
    if (!CC_COLLISION_HANDLER_RESET_InLow) begin
      r_state    <= S_PLAY;
      r_row      <= '0;
      r_held     <= '0;
      r_lives    <= LIVES_RST;
      r_blink    <= '0;
      r_freeze   <= 1'b0;
      r_respawn  <= 1'b0;
      r_gameover <= 1'b0;
`ifdef CC_COLLISION_HANDLER_SCORE_EN
      r_score    <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_row      <= w_row_nxt;
      r_held     <= w_held_nxt;
      r_lives    <= w_lives_nxt;
      r_blink    <= w_blink_nxt;
      r_freeze   <= w_freeze_nxt;
      r_respawn  <= w_respawn_nxt;
      r_gameover <= w_gameover_nxt;
`ifdef CC_COLLISION_HANDLER_SCORE_EN
      r_score    <= w_score_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_row_nxt      = r_row;
    w_held_nxt     = r_held;
    w_lives_nxt    = r_lives;
    w_blink_nxt    = r_blink;
    w_freeze_nxt   = r_freeze;
    w_respawn_nxt  = r_respawn;
    w_gameover_nxt = r_gameover;
    case (r_state)
      S_PLAY: begin
        if (!bus.PlayerLose_InLow) begin
          // Comparator zeroes the row on a hit, so show the last clean one.
          w_state_nxt  = S_HIT;
          w_lives_nxt  = (r_lives == '0) ? '0 : r_lives - LIVESWIDTH'(1);
          w_freeze_nxt = 1'b1;
          w_row_nxt    = r_held;
          w_blink_nxt  = '0;
        end else begin
          w_row_nxt  = bus.RowData_InBus;
          w_held_nxt = bus.RowData_InBus;
        end
      end
      S_HIT: begin
        if (bus.Tick_InHigh) begin
          w_blink_nxt = r_blink + BLINKWIDTH'(1);
          w_row_nxt   = r_blink[0] ? r_held : '0;
          if (r_blink == BLINK_LAST) begin
            if (r_lives == '0) begin
              w_state_nxt    = S_GAMEOVER;
              w_gameover_nxt = 1'b1;
              w_row_nxt      = '1;
            end else begin
              w_state_nxt   = S_RESPAWN;
              w_respawn_nxt = 1'b1;
            end
          end
        end
      end
      S_RESPAWN: begin
        w_state_nxt   = S_PLAY;
        w_respawn_nxt = 1'b0;
        w_freeze_nxt  = 1'b0;
      end
      S_GAMEOVER: begin
        if (bus.Restart_InHigh) begin
          w_state_nxt    = S_RESPAWN;
          w_lives_nxt    = LIVES_RST;
          w_gameover_nxt = 1'b0;
          w_respawn_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_PLAY;
    endcase
  end

`ifdef CC_COLLISION_HANDLER_SCORE_EN
  always_comb begin
    w_score_nxt = r_score;
    if (r_state == S_PLAY && bus.PlayerLose_InLow && bus.Tick_InHigh && r_score != '1)
      w_score_nxt = r_score + SCOREWIDTH'(1);
    else if (r_state == S_GAMEOVER && bus.Restart_InHigh)
      w_score_nxt = '0;
  end
  assign bus.Score_OutBus = r_score;
`endif

  assign bus.RowData_OutBus   = r_row;
  assign bus.Lives_OutBus     = r_lives;
  assign bus.Freeze_OutHigh   = r_freeze;
  assign bus.Respawn_OutHigh  = r_respawn;
  assign bus.GameOver_OutHigh = r_gameover;
endmodule

// File: tb/tb_cc_collision_handler.sv
// tb/tb_cc_collision_handler.sv - directed and random stimulus checked against a behavioural lives/blink model.
// Score checks compile in when CC_COLLISION_HANDLER_SCORE_EN is defined.
module tb_cc_collision_handler;
  localparam int BLINK = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  // Model: mode 0 play, 1 hit, 2 respawn, 3 game over
  int m_mode, m_lives, m_row, m_held, m_ticks, m_score, m_freeze, m_resp, m_go;

  cc_collision_handler_if #(.DATAWIDTH(8), .LIVESWIDTH(2), .SCOREWIDTH(8)) bus ();

  cc_collision_handler #(
    .DATAWIDTH(8), .LIVES_INIT(3), .LIVESWIDTH(2),
    .BLINK_TICKS(BLINK), .BLINKWIDTH(3), .SCOREWIDTH(8)
  ) dut (
    .CC_COLLISION_HANDLER_CLOCK_50   (clk),
    .CC_COLLISION_HANDLER_RESET_InLow(rst_n),
    .bus                             (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_lives = 3; m_row = 0; m_held = 0; m_ticks = 0;
    m_score = 0; m_freeze = 0; m_resp = 0; m_go = 0;
  endtask

  task automatic model_step(input logic lose_n, input logic [7:0] row, input logic tick, input logic rst_req);
    case (m_mode)
      0: if (!lose_n) begin
           m_mode = 1; m_lives = (m_lives > 0) ? m_lives - 1 : 0;
           m_freeze = 1; m_row = m_held; m_ticks = 0;
         end else begin
           m_row = row; m_held = row;
           if (tick && m_score < 255) m_score = m_score + 1;
         end
      1: if (tick) begin
           m_ticks = m_ticks + 1;
           m_row = (m_ticks % 2 == 1) ? 0 : m_held;
           if (m_ticks == BLINK) begin
             if (m_lives == 0) begin m_mode = 3; m_go = 1; m_row = 255; end
             else begin m_mode = 2; m_resp = 1; end
           end
         end
      2: begin m_mode = 0; m_resp = 0; m_freeze = 0; end
      default: if (rst_req) begin
           m_mode = 2; m_lives = 3; m_go = 0; m_resp = 1; m_score = 0;
         end
    endcase
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_row"},     32'(bus.RowData_OutBus),   32'(m_row));
    chk({tag, "_lives"},   32'(bus.Lives_OutBus),     32'(m_lives));
    chk({tag, "_freeze"},  32'(bus.Freeze_OutHigh),   32'(m_freeze));
    chk({tag, "_respawn"}, 32'(bus.Respawn_OutHigh),  32'(m_resp));
    chk({tag, "_gameover"},32'(bus.GameOver_OutHigh), 32'(m_go));
`ifdef CC_COLLISION_HANDLER_SCORE_EN
    chk({tag, "_score"},   32'(bus.Score_OutBus),     32'(m_score));
`endif
  endtask

  task automatic cyc(input string tag, input logic lose_n, input logic [7:0] row,
                     input logic tick, input logic rst_req);
    @(negedge clk);
    bus.PlayerLose_InLow = lose_n;
    bus.RowData_InBus    = row;
    bus.Tick_InHigh      = tick;
    bus.Restart_InHigh   = rst_req;
    @(posedge clk);
    model_step(lose_n, row, tick, rst_req);
    #1;
    check_all(tag);
  endtask

  logic [7:0] blink_exp [6];

  initial begin
    blink_exp[0] = 8'h00; blink_exp[1] = 8'h24; blink_exp[2] = 8'h00;
    blink_exp[3] = 8'h24; blink_exp[4] = 8'h00; blink_exp[5] = 8'h24;
    bus.PlayerLose_InLow = 1'b1;
    bus.RowData_InBus    = 8'h00;
    bus.Tick_InHigh      = 1'b0;
    bus.Restart_InHigh   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Pass-through in PLAY
    cyc("t1", 1'b1, 8'h24, 1'b0, 1'b0);
    chk("t1_row_const", 32'(bus.RowData_OutBus), 32'h24);
    chk("t1_lives_const", 32'(bus.Lives_OutBus), 32'd3);

    // First collision and blink sequence
    cyc("t2_hit", 1'b0, 8'h00, 1'b0, 1'b0);
    chk("t2_lives_const", 32'(bus.Lives_OutBus), 32'd2);
    chk("t2_freeze_const", 32'(bus.Freeze_OutHigh), 32'd1);
    for (int i = 0; i < BLINK; i++) begin
      cyc("t2_blink", 1'b0, 8'h00, 1'b1, 1'b1);
      chk("t2_blink_row", 32'(bus.RowData_OutBus), 32'(blink_exp[i]));
    end
    chk("t2_respawn_const", 32'(bus.Respawn_OutHigh), 32'd1);
    cyc("t2_play", 1'b1, 8'h24, 1'b0, 1'b0);
    chk("t2_respawn_done", 32'(bus.Respawn_OutHigh), 32'd0);
    chk("t2_unfrozen", 32'(bus.Freeze_OutHigh), 32'd0);

    // Ten ticks of survival, then two more collisions down to game over
    for (int i = 0; i < 10; i++) cyc("t6_tick", 1'b1, 8'h24, 1'b1, 1'b0);
`ifdef CC_COLLISION_HANDLER_SCORE_EN
    chk("t6_score_const", 32'(bus.Score_OutBus), 32'd10);
`endif
    for (int k = 0; k < 2; k++) begin
      cyc("t3_hit", 1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < BLINK; i++) begin
        cyc("t3_idle", 1'b1, 8'h00, 1'b0, 1'b0);
        cyc("t3_blink", 1'b1, 8'h00, 1'b1, 1'b0);
      end
      if (k == 0) cyc("t3_resp", 1'b1, 8'h81, 1'b0, 1'b0);
    end
    chk("t3_lives_const", 32'(bus.Lives_OutBus), 32'd0);
    chk("t3_go_const", 32'(bus.GameOver_OutHigh), 32'd1);
    chk("t3_row_ff", 32'(bus.RowData_OutBus), 32'hFF);
    chk("t3_no_respawn", 32'(bus.Respawn_OutHigh), 32'd0);

    // Restart from game over, then restart ignored in PLAY
    cyc("t4_go_wait", 1'b0, 8'h11, 1'b1, 1'b0);
    cyc("t4_restart", 1'b1, 8'h00, 1'b0, 1'b1);
    chk("t4_respawn_const", 32'(bus.Respawn_OutHigh), 32'd1);
    chk("t4_lives_const", 32'(bus.Lives_OutBus), 32'd3);
    chk("t4_go_clear", 32'(bus.GameOver_OutHigh), 32'd0);
`ifdef CC_COLLISION_HANDLER_SCORE_EN
    chk("t4_score_zero", 32'(bus.Score_OutBus), 32'd0);
`endif
    cyc("t4_back", 1'b1, 8'h5A, 1'b0, 1'b0);
    cyc("t4_restart_play", 1'b1, 8'h5A, 1'b0, 1'b1);
    chk("t4_restart_ignored", 32'(bus.Lives_OutBus), 32'd3);

    // Tick coincident with collision, then reset mid-HIT
    cyc("t5_hit_tick", 1'b0, 8'h00, 1'b1, 1'b0);
    cyc("t5_first_blink", 1'b1, 8'h00, 1'b1, 1'b0);
    chk("t5_first_blank", 32'(bus.RowData_OutBus), 32'h00);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("t5_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic against the model
    for (int i = 0; i < 600; i++)
      cyc("rnd", ($urandom_range(0, 7) != 0), 8'($urandom), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 4) == 0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
